// File: rtl/nn_stream_framer_if.sv
// Pixel stream bundle between the camera side and the framer output toward conv_nn.
// Optional err_cnt_o member exists only when NN_FRAMER_ERR_CNT_EN is defined.
interface nn_stream_framer_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data_i;
    logic                  data_valid_i;
    logic                  frame_start_i;
    logic [DATA_WIDTH-1:0] data_o;
    logic                  data_valid_o;
    logic                  sop_o;
    logic                  eop_o;
    logic                  sof_o;
    logic                  eof_o;
    logic                  busy_o;
    logic                  err_o;
`ifdef NN_FRAMER_ERR_CNT_EN
    logic [15:0]           err_cnt_o;
`endif

    modport slave (
`ifdef NN_FRAMER_ERR_CNT_EN
        output err_cnt_o,
`endif
        input  data_i, data_valid_i, frame_start_i,
        output data_o, data_valid_o, sop_o, eop_o, sof_o, eof_o, busy_o, err_o
    );

    modport master (
`ifdef NN_FRAMER_ERR_CNT_EN
        input  err_cnt_o,
`endif
        output data_i, data_valid_i, frame_start_i,
        input  data_o, data_valid_o, sop_o, eop_o, sof_o, eof_o, busy_o, err_o
    );
endinterface

// File: rtl/nn_stream_framer.sv
// Frames a raw camera pixel stream into lines/frames with sop/eop/sof/eof markers.
// Define NN_FRAMER_ERR_CNT_EN to add the saturating 16-bit framing-error counter.
module nn_stream_framer #(
    parameter int DATA_WIDTH = 8,
    parameter int LINE_LEN   = 320,
    parameter int LINE_NUM   = 240
) (
    input  logic                clk,
    input  logic                reset,
    nn_stream_framer_if.slave   bus
);
    localparam int CW = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
    localparam int RW = (LINE_NUM > 1) ? $clog2(LINE_NUM) : 1;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                state_q;
    logic [CW-1:0]         col_q;
    logic [RW-1:0]         row_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q, sop_q, eop_q, sof_q, eof_q, err_q;

    logic                  start, cur_eof, restart, emit, err_d;
    logic [CW-1:0]         pos_col, col_d;
    logic [RW-1:0]         pos_row, row_d;
    logic                  p_sop, p_eop, p_sof, p_eof;

    assign start   = bus.data_valid_i & bus.frame_start_i;
    assign cur_eof = (col_q == CW'(LINE_LEN - 1)) && (row_q == RW'(LINE_NUM - 1));
    // A start landing on the pixel that completes the frame closes it instead of restarting.
    assign restart = start && !((state_q == ACTIVE) && cur_eof);
    assign emit    = bus.data_valid_i && ((state_q == ACTIVE) || start);
    assign err_d   = start && (state_q == ACTIVE);

    assign pos_col = restart ? '0 : col_q;
    assign pos_row = restart ? '0 : row_q;
    assign p_sop   = (pos_col == '0);
    assign p_eop   = (pos_col == CW'(LINE_LEN - 1));
    assign p_sof   = p_sop && (pos_row == '0);
    assign p_eof   = p_eop && (pos_row == RW'(LINE_NUM - 1));

    always_comb begin
        col_d = pos_col + CW'(1);
        row_d = pos_row;
        if (p_eof) begin
            col_d = '0;
            row_d = '0;
        end else if (p_eop) begin
            col_d = '0;
            row_d = pos_row + RW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= emit;
            sop_q   <= emit & p_sop;
            eop_q   <= emit & p_eop;
            sof_q   <= emit & p_sof;
            eof_q   <= emit & p_eof;
            err_q   <= err_d;
            if (emit) begin
                data_q  <= bus.data_i;
                col_q   <= col_d;
                row_q   <= row_d;
                state_q <= p_eof ? IDLE : ACTIVE;
            end
        end
    end

    assign bus.data_o       = data_q;
    assign bus.data_valid_o = valid_q;
    assign bus.sop_o        = sop_q;
    assign bus.eop_o        = eop_q;
    assign bus.sof_o        = sof_q;
    assign bus.eof_o        = eof_q;
    assign bus.err_o        = err_q;
    assign bus.busy_o       = (state_q == ACTIVE);

`ifdef NN_FRAMER_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else if (err_d && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign bus.err_cnt_o = err_cnt_q;
`endif
endmodule

// File: tb/tb_nn_stream_framer.sv
// Directed frame scenarios plus random traffic checked against a pixel-index
// reference model of the framer.
module tb_nn_stream_framer;
    localparam int DW    = 8;
    localparam int LL    = 4;
    localparam int LN    = 3;
    localparam int TOTAL = LL * LN;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    nn_stream_framer_if #(.DATA_WIDTH(DW)) bus ();

    nn_stream_framer #(
        .DATA_WIDTH (DW),
        .LINE_LEN   (LL),
        .LINE_NUM   (LN)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // model state: whether a frame is open and the index of the next pixel in it
    bit          in_frame = 1'b0;
    int          k        = 0;
    logic [DW-1:0] exp_data = '0;
    bit          exp_valid, exp_sop, exp_eop, exp_sof, exp_eof, exp_busy, exp_err;
    int          exp_err_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model(input bit rst, input bit v, input bit s, input logic [DW-1:0] d);
        bit emit = 1'b0;
        int idx  = 0;
        exp_err = 1'b0;
        if (rst) begin
            in_frame    = 1'b0;
            k           = 0;
            exp_data    = '0;
            exp_err_cnt = 0;
        end else if (v) begin
            if (s && in_frame && k == TOTAL - 1) begin
                emit = 1'b1; idx = k; exp_err = 1'b1;
                in_frame = 1'b0; k = 0;
            end else if (s) begin
                exp_err = in_frame;
                emit = 1'b1; idx = 0; k = 1; in_frame = 1'b1;
                if (k == TOTAL) begin in_frame = 1'b0; k = 0; end
            end else if (in_frame) begin
                emit = 1'b1; idx = k; k++;
                if (k == TOTAL) begin in_frame = 1'b0; k = 0; end
            end
        end
        if (exp_err && exp_err_cnt < 65535) exp_err_cnt++;
        exp_valid = emit;
        exp_sop   = emit && (idx % LL == 0);
        exp_eop   = emit && (idx % LL == LL - 1);
        exp_sof   = emit && (idx == 0);
        exp_eof   = emit && (idx == TOTAL - 1);
        exp_busy  = in_frame;
        if (emit) exp_data = d;
    endtask

    task automatic cycle(input bit rst, input bit v, input bit s, input logic [DW-1:0] d);
        reset             = rst;
        bus.data_valid_i  = v;
        bus.frame_start_i = s;
        bus.data_i        = d;
        model(rst, v, s, d);
        @(posedge clk);
        #1;
        cyc++;
        check_val("valid", 32'(bus.data_valid_o), 32'(exp_valid));
        check_val("sop_eop_sof_eof", 32'({bus.sop_o, bus.eop_o, bus.sof_o, bus.eof_o}),
                  32'({exp_sop, exp_eop, exp_sof, exp_eof}));
        check_val("data", 32'(bus.data_o), 32'(exp_data));
        check_val("busy", 32'(bus.busy_o), 32'(exp_busy));
        check_val("err", 32'(bus.err_o), 32'(exp_err));
`ifdef NN_FRAMER_ERR_CNT_EN
        check_val("err_cnt", 32'(bus.err_cnt_o), 32'(exp_err_cnt));
`endif
    endtask

    task automatic clean_frame(input bit gapped);
        for (int i = 0; i < TOTAL; i++) begin
            cycle(1'b0, 1'b1, i == 0, DW'(i));
            if (gapped) cycle(1'b0, 1'b0, 1'b1, 8'hEE);
        end
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        reset = 1'b1;
        bus.data_valid_i = 1'b0;
        bus.frame_start_i = 1'b0;
        bus.data_i = '0;
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b1, 1'b1, 8'h55);

        clean_frame(1'b0);
        clean_frame(1'b1);

        // short frame: restart on pixel 6, then 11 more pixels close it
        for (int i = 0; i < 18; i++) cycle(1'b0, 1'b1, (i == 0) || (i == 6), DW'(i));
        cycle(1'b0, 1'b0, 1'b0, 8'h00);

        // start on the closing pixel of a frame
        for (int i = 0; i < TOTAL; i++) cycle(1'b0, 1'b1, (i == 0) || (i == TOTAL - 1), DW'(i + 8'h40));
        cycle(1'b0, 1'b1, 1'b0, 8'h99);

        // junk before the frame
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, DW'(8'hA0 + i));
        clean_frame(1'b0);

        // reset in the middle of a frame
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, i == 0, DW'(i));
        cycle(1'b1, 1'b1, 1'b0, 8'h07);
        for (int i = 8; i < 12; i++) cycle(1'b0, 1'b1, 1'b0, DW'(i));

        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 29) == 0, DW'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
